// File: rtl/cpu_timing_pkg.sv
// Shared types and constants for the CPU cycle-timing sequencer.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ,
        FETCH,
        EXEC,
        INT_SEQ
    } seq_state_t;

    localparam logic [1:0] VEC_NONE  = 2'b00;
    localparam logic [1:0] VEC_IRQ   = 2'b01;
    localparam logic [1:0] VEC_NMI   = 2'b10;
    localparam logic [1:0] VEC_RESET = 2'b11;

    localparam int DEF_RESET_CYCLES = 7;
    localparam int DEF_INT_CYCLES   = 7;
    localparam int DEF_MIN_CYCLES   = 2;

    // Predecode may report lengths below the hardware minimum; raise them.
    function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] min_len);
        return (len < min_len) ? min_len : len;
    endfunction

endpackage

// File: rtl/timing_sequencer_nmi_edge_latch.sv
// Rising-edge detector on nmi with a sticky pending flag cleared when the sequencer takes it.
module nmi_edge_latch (
    input  logic clk,
    input  logic nrst,
    input  logic nmi,
    input  logic clear,
    output logic pending
);

    logic nmi_prev;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmi_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            nmi_prev <= nmi;
            // An edge landing in the same cycle as the clear is a new request and must survive.
            pending  <= (pending & ~clear) | (nmi & ~nmi_prev);
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// T-state sequencer: reset sequence, fetch/execute stepping, interrupt arbitration and RDY stall.
module timing_sequencer
    import cpu_timing_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int INT_CYCLES   = DEF_INT_CYCLES,
    parameter int MIN_CYCLES   = DEF_MIN_CYCLES
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ready,
    input  logic [2:0] cycle_count_in,
    input  logic       nmi,
    input  logic       irq,
    input  logic       i_flag,
    output logic [2:0] tstate,
    output logic       sync,
    output logic       load_ir,
    output logic       pc_inc,
    output logic       last_cycle,
    output logic       int_active,
    output logic [1:0] vector_sel
);

    localparam logic [2:0] RESET_LAST = 3'(RESET_CYCLES - 1);
    localparam logic [2:0] INT_LAST   = 3'(INT_CYCLES);
    localparam logic [2:0] MIN_LEN    = 3'(MIN_CYCLES);

    seq_state_t state, state_nxt;
    logic [2:0] count, count_nxt;
    logic [2:0] length, length_nxt;
    logic [1:0] vec, vec_nxt;
    logic       nmi_pending, nmi_clear, irq_req;

    nmi_edge_latch u_nmi (
        .clk     (clk),
        .nrst    (nrst),
        .nmi     (nmi),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    assign irq_req = irq & ~i_flag;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= RESET_SEQ;
            count  <= 3'd0;
            length <= MIN_LEN;
            vec    <= VEC_RESET;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            length <= length_nxt;
            vec    <= vec_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        length_nxt = length;
        vec_nxt    = vec;
        nmi_clear  = 1'b0;
        tstate     = count;
        sync       = 1'b0;
        load_ir    = 1'b0;
        pc_inc     = 1'b0;
        last_cycle = 1'b0;
        int_active = 1'b0;
        vector_sel = vec;

        case (state)
            RESET_SEQ: begin
                tstate     = 3'd0;
                int_active = 1'b1;
                last_cycle = (count == RESET_LAST);
                if (ready) begin
                    if (last_cycle) begin
                        state_nxt = FETCH;
                        count_nxt = 3'd1;
                        vec_nxt   = VEC_NONE;
                    end else begin
                        count_nxt = count + 3'd1;
                    end
                end
            end
            FETCH: begin
                sync    = 1'b1;
                load_ir = ready;
                pc_inc  = ready;
                if (ready) begin
                    length_nxt = clamp_len(cycle_count_in, MIN_LEN);
                    state_nxt  = EXEC;
                    count_nxt  = 3'd2;
                end
            end
            EXEC: begin
                last_cycle = (count == length);
                if (ready) begin
                    if (last_cycle) begin
                        count_nxt = 3'd1;
                        // Instruction boundary: NMI outranks an unmasked IRQ.
                        if (nmi_pending) begin
                            state_nxt = INT_SEQ;
                            vec_nxt   = VEC_NMI;
                            nmi_clear = 1'b1;
                        end else if (irq_req) begin
                            state_nxt = INT_SEQ;
                            vec_nxt   = VEC_IRQ;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end else begin
                        count_nxt = count + 3'd1;
                    end
                end
            end
            INT_SEQ: begin
                int_active = 1'b1;
                last_cycle = (count == INT_LAST);
                if (ready) begin
                    if (last_cycle) begin
                        state_nxt = FETCH;
                        count_nxt = 3'd1;
                        vec_nxt   = VEC_NONE;
                    end else begin
                        count_nxt = count + 3'd1;
                    end
                end
            end
            default: state_nxt = RESET_SEQ;
        endcase
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: directed scenarios plus randomized traffic against a queue-based cycle model.
module tb_timing_sequencer;
    import cpu_timing_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       ready = 1'b0;
    logic [2:0] cycle_count_in = 3'd0;
    logic       nmi = 1'b0;
    logic       irq = 1'b0;
    logic       i_flag = 1'b1;
    logic [2:0] tstate;
    logic       sync, load_ir, pc_inc, last_cycle, int_active;
    logic [1:0] vector_sel;

    int checks = 0;
    int errors = 0;

    logic [2:0] obs_t;
    logic       obs_sync, obs_last, obs_int, obs_ld, obs_pc;
    logic [1:0] obs_vec;

    // Model: queue of cycles still to come; each entry is what the outputs must show on that cycle.
    typedef struct {
        logic [2:0] t;
        bit         last;
        bit         intr;
        logic [1:0] vec;
        bit         fetch;
    } slot_t;

    slot_t q[$];
    bit    m_pend;
    bit    m_prev;

    timing_sequencer dut (
        .clk            (clk),
        .nrst           (nrst),
        .ready          (ready),
        .cycle_count_in (cycle_count_in),
        .nmi            (nmi),
        .irq            (irq),
        .i_flag         (i_flag),
        .tstate         (tstate),
        .sync           (sync),
        .load_ir        (load_ir),
        .pc_inc         (pc_inc),
        .last_cycle     (last_cycle),
        .int_active     (int_active),
        .vector_sel     (vector_sel)
    );

    always #5 clk = ~clk;

    function automatic void push_reset_seq();
        for (int i = 0; i < 7; i++) q.push_back('{3'd0, i == 6, 1'b1, VEC_RESET, 1'b0});
    endfunction

    function automatic void push_fetch();
        q.push_back('{3'd1, 1'b0, 1'b0, VEC_NONE, 1'b1});
    endfunction

    function automatic void push_body(input int len);
        for (int t = 2; t <= len; t++) q.push_back('{3'(t), t == len, 1'b0, VEC_NONE, 1'b0});
    endfunction

    function automatic void push_int(input logic [1:0] v);
        for (int t = 1; t <= 7; t++) q.push_back('{3'(t), t == 7, 1'b1, v, 1'b0});
    endfunction

    // One clock: drive inputs, compare against model at the falling edge, advance model, end just past the rising edge.
    task automatic step(input bit r, input logic [2:0] cc, input bit n, input bit ir, input bit f);
        slot_t h;
        bit    take_nmi;
        int    len;
        ready = r; cycle_count_in = cc; nmi = n; irq = ir; i_flag = f;
        @(negedge clk);
        obs_t = tstate; obs_sync = sync; obs_last = last_cycle; obs_int = int_active;
        obs_vec = vector_sel; obs_ld = load_ir; obs_pc = pc_inc;
        take_nmi = 1'b0;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL model_empty: no expected cycle available at %0t", $time);
        end else begin
            h = q[0];
            checks++;
            if ({tstate, sync, last_cycle, int_active, vector_sel, load_ir, pc_inc} !==
                {h.t, h.fetch, h.last, h.intr, h.vec, h.fetch & r, h.fetch & r}) begin
                errors++;
                $display("FAIL cycle_outputs @%0t: got t=%0d sync=%b last=%b int=%b vec=%b ld=%b pc=%b, want t=%0d sync=%b last=%b int=%b vec=%b ld=%b pc=%b",
                         $time, tstate, sync, last_cycle, int_active, vector_sel, load_ir, pc_inc,
                         h.t, h.fetch, h.last, h.intr, h.vec, h.fetch & r, h.fetch & r);
            end
            if (r) begin
                void'(q.pop_front());
                if (h.fetch) begin
                    len = (cc < 3'd2) ? 2 : int'(cc);
                    push_body(len);
                end else if (h.last && h.intr) begin
                    push_fetch();
                end else if (h.last) begin
                    if (m_pend) begin
                        take_nmi = 1'b1;
                        push_int(VEC_NMI);
                    end else if (ir && !f) begin
                        push_int(VEC_IRQ);
                    end else begin
                        push_fetch();
                    end
                end
            end
        end
        m_pend = (m_pend && !take_nmi) || (n && !m_prev);
        m_prev = n;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({tstate, sync, load_ir, pc_inc, last_cycle, int_active, vector_sel} !==
            {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, VEC_RESET}) begin
            errors++;
            $display("FAIL reset_values: got t=%0d sync=%b ld=%b pc=%b last=%b int=%b vec=%b, want t=0 sync=0 ld=0 pc=0 last=0 int=1 vec=11",
                     tstate, sync, load_ir, pc_inc, last_cycle, int_active, vector_sel);
        end
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        q.delete();
        push_reset_seq();
        m_pend = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic run_to_fetch();
        for (int i = 0; i < 50; i++) begin
            if (q.size() != 0 && q[0].fetch) return;
            step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        end
        checks++; errors++;
        $display("FAIL fetch_timeout: no fetch cycle within 50 cycles");
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_t !== 3'd0 || obs_vec !== VEC_RESET || obs_last !== (i == 6)) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got t=%0d vec=%b last=%b, want t=0 vec=11 last=%b",
                         i, obs_t, obs_vec, obs_last, i == 6);
            end
        end
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_sync !== 1'b1 || obs_t !== 3'd1 || obs_ld !== 1'b1 || obs_int !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: got sync=%b t=%0d ld=%b int=%b, want sync=1 t=1 ld=1 int=0",
                     obs_sync, obs_t, obs_ld, obs_int);
        end
    endtask

    task automatic test_length();
        int exp4[5] = '{1, 2, 3, 4, 1};
        int exp0[3] = '{1, 2, 1};
        run_to_fetch();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 0) ? 3'd4 : 3'd2, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_t !== 3'(exp4[i]) || obs_last !== (exp4[i] == 4)) begin
                errors++;
                $display("FAIL len4[%0d]: got t=%0d last=%b, want t=%0d last=%b",
                         i, obs_t, obs_last, exp4[i], exp4[i] == 4);
            end
        end
        run_to_fetch();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i == 0) ? 3'd0 : 3'd2, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_t !== 3'(exp0[i]) || obs_last !== (i == 1)) begin
                errors++;
                $display("FAIL len_clamp[%0d]: got t=%0d last=%b, want t=%0d last=%b",
                         i, obs_t, obs_last, exp0[i], i == 1);
            end
        end
    endtask

    task automatic test_stall();
        int exp_t[8]  = '{1, 2, 3, 3, 3, 3, 4, 5};
        bit exp_r[8]  = '{1, 1, 0, 0, 0, 1, 1, 1};
        run_to_fetch();
        for (int i = 0; i < 8; i++) begin
            step(exp_r[i], 3'd5, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_t !== 3'(exp_t[i]) || obs_pc !== (i == 0) || obs_last !== (i == 7)) begin
                errors++;
                $display("FAIL stall[%0d]: got t=%0d pc=%b last=%b, want t=%0d pc=%b last=%b",
                         i, obs_t, obs_pc, obs_last, exp_t[i], i == 0, i == 7);
            end
        end
    endtask

    task automatic test_irq();
        run_to_fetch();
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_t !== 3'(i + 1) || obs_vec !== VEC_IRQ || obs_int !== 1'b1 ||
                obs_pc !== 1'b0 || obs_sync !== 1'b0 || obs_last !== (i == 6)) begin
                errors++;
                $display("FAIL irq_seq[%0d]: got t=%0d vec=%b int=%b pc=%b sync=%b last=%b, want t=%0d vec=01 int=1 pc=0 sync=0 last=%b",
                         i, obs_t, obs_vec, obs_int, obs_pc, obs_sync, obs_last, i + 1, i == 6);
            end
        end
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_sync !== 1'b1 || obs_vec !== VEC_NONE) begin
            errors++;
            $display("FAIL irq_return: got sync=%b vec=%b, want sync=1 vec=00", obs_sync, obs_vec);
        end
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs_sync !== 1'b1 || obs_int !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got sync=%b int=%b, want sync=1 int=0", obs_sync, obs_int);
        end
    endtask

    task automatic test_nmi();
        run_to_fetch();
        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== VEC_NMI || obs_t !== 3'(i + 1) || obs_int !== 1'b1) begin
                errors++;
                $display("FAIL nmi_seq[%0d]: got vec=%b t=%0d int=%b, want vec=10 t=%0d int=1",
                         i, obs_vec, obs_t, obs_int, i + 1);
            end
        end
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec !== VEC_IRQ || obs_int !== 1'b1 || obs_t !== 3'd1) begin
            errors++;
            $display("FAIL irq_after_nmi: got vec=%b int=%b t=%0d, want vec=01 int=1 t=1",
                     obs_vec, obs_int, obs_t);
        end
    endtask

    task automatic test_reset_mid();
        run_to_fetch();
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        test_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 11) == 0, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        m_pend = 1'b0;
        m_prev = 1'b0;
        test_reset();
        test_length();
        test_stall();
        test_irq();
        test_nmi();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
